// File: rtl/startup_seq_ctrl.sv
// Power-up sequencer: holds global set/reset and tristate, qualifies PLL lock,
// then releases gsr, gts and finally enables global writes.
module startup_seq_ctrl #(
  parameter int unsigned ROC_CYCLES   = 100,
  parameter int unsigned TOC_CYCLES   = 4,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       gsr,
  output logic       prld,
  output logic       gts,
  output logic       gwe,
  output logic       done,
  output logic       error,
  output logic       lock_lost,
  output logic [2:0] state
);

  localparam int unsigned MaxA   = (ROC_CYCLES > TOC_CYCLES) ? ROC_CYCLES : TOC_CYCLES;
  localparam int unsigned MaxB   = (LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] RocLast     = CntW'(ROC_CYCLES - 1);
  localparam logic [CntW-1:0] TocLast     = CntW'(TOC_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StRoc      = 3'd0,
    StWaitLock = 3'd1,
    StRelGsr   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] stab_q, stab_d;
  logic            lock_lost_q, lock_lost_d;
  logic            gsr_q, gsr_d;
  logic            gts_q, gts_d;
  logic            gwe_q, gwe_d;
  logic            error_q, error_d;

  // Counters default to zero so every transition clears them on entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    stab_d      = '0;
    lock_lost_d = lock_lost_q;

    case (state_q)
      StRoc: begin
        if (cnt_q == RocLast) state_d = StWaitLock;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StWaitLock: begin
        // Lock qualification takes priority over the timeout on the same cycle.
        if (pll_locked && (stab_q == StableLast)) begin
          state_d = StRelGsr;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFail;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          stab_d = pll_locked ? (stab_q + 1'b1) : '0;
        end
      end
      StRelGsr: begin
        if (!pll_locked)          state_d = StRoc;
        else if (cnt_q == TocLast) state_d = StRun;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      StRun: begin
        if (!pll_locked) begin
          state_d     = StRoc;
          lock_lost_d = 1'b1;
        end
      end
      StFail:  state_d = StFail;
      default: state_d = StRoc;
    endcase

    if (restart) begin
      state_d     = StRoc;
      cnt_d       = '0;
      stab_d      = '0;
      lock_lost_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so the registered copies track state_q.
  always_comb begin
    gsr_d   = (state_d == StRoc) || (state_d == StWaitLock) || (state_d == StFail);
    gts_d   = (state_d != StRun);
    gwe_d   = (state_d == StRun);
    error_d = (state_d == StFail);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRoc;
      cnt_q       <= '0;
      stab_q      <= '0;
      lock_lost_q <= 1'b0;
      gsr_q       <= 1'b1;
      gts_q       <= 1'b1;
      gwe_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      lock_lost_q <= lock_lost_d;
      gsr_q       <= gsr_d;
      gts_q       <= gts_d;
      gwe_q       <= gwe_d;
      error_q     <= error_d;
    end
  end

  assign gsr       = gsr_q;
  assign prld      = gsr_q;
  assign gts       = gts_q;
  assign gwe       = gwe_q;
  assign done      = gwe_q;
  assign error     = error_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Bench for startup_seq_ctrl: directed sequence checks plus randomized lock/restart/reset
// traffic compared every cycle against a cycle-counting reference model.
module tb_startup_seq_ctrl;

  localparam int unsigned ROC     = 8;
  localparam int unsigned TOC     = 4;
  localparam int unsigned STABLE  = 3;
  localparam int unsigned TIMEOUT = 20;

  localparam int SRoc = 0, SWait = 1, SRel = 2, SRun = 3, SFail = 4;

  logic       clk, resetn, pll_locked, restart;
  logic       gsr, prld, gts, gwe, done, error, lock_lost;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  startup_seq_ctrl #(
    .ROC_CYCLES  (ROC),
    .TOC_CYCLES  (TOC),
    .LOCK_STABLE (STABLE),
    .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_locked(pll_locked),
    .restart   (restart),
    .gsr       (gsr),
    .prld      (prld),
    .gts       (gts),
    .gwe       (gwe),
    .done      (done),
    .error     (error),
    .lock_lost (lock_lost),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks which phase we are in, how many cycles it has lasted and
  // how many consecutive locked samples have been seen while waiting for lock.
  int m_st = SRoc, m_age = 0, m_run = 0;
  bit m_ll = 0;

  function automatic logic [9:0] expect_vec(input int st, input bit ll);
    logic held, run, fail;
    held = (st == SRoc) || (st == SWait) || (st == SFail);
    run  = (st == SRun);
    fail = (st == SFail);
    return {3'(st), held, held, (st != SRun), run, run, fail, ll};
  endfunction

  task automatic go(input int st);
    m_st  = st;
    m_age = 0;
    m_run = 0;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      go(SRoc);
      m_ll = 0;
    end else if (restart) begin
      go(SRoc);
      m_ll = 0;
    end else begin
      case (m_st)
        SRoc: begin
          m_age++;
          if (m_age == ROC) go(SWait);
        end
        SWait: begin
          m_run = pll_locked ? m_run + 1 : 0;
          m_age++;
          if (m_run == STABLE)        go(SRel);
          else if (m_age == TIMEOUT) go(SFail);
        end
        SRel: begin
          if (!pll_locked) go(SRoc);
          else begin
            m_age++;
            if (m_age == TOC) go(SRun);
          end
        end
        SRun: begin
          if (!pll_locked) begin
            go(SRoc);
            m_ll = 1;
          end
        end
        default: ;
      endcase
    end
  end

  wire [9:0] dut_vec = {state, gsr, prld, gts, gwe, done, error, lock_lost};

  always @(negedge clk) begin
    if (chk_en) check("model_outs", dut_vec, expect_vec(m_st, m_ll));
  end

  localparam logic [9:0] RstVec = 10'b000_111_0000;
  bit pat [6] = '{1, 1, 0, 1, 1, 1};

  initial begin
    int mode;
    resetn     = 1'b0;
    pll_locked = 1'b1;
    restart    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", dut_vec, RstVec);
    chk_en = 1;

    // Clean startup: RUN reached after edge 14.
    resetn = 1'b1;
    repeat (14) @(negedge clk);
    check("done_c14", done, 0);
    @(negedge clk);
    check("done_c15", done, 1);
    check("gsr_c15", gsr, 0);

    // One-cycle lock drop in RUN.
    repeat (3) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    check("drop_state", state, SRoc);
    check("drop_ll", lock_lost, 1);
    check("drop_gwe", gwe, 0);
    repeat (16) @(negedge clk);
    check("rerun_state", state, SRun);
    check("ll_sticky", lock_lost, 1);

    // Restart clears lock_lost; then permanent lock loss times out.
    restart = 1'b1;
    @(negedge clk);
    restart    = 1'b0;
    pll_locked = 1'b0;
    check("rs_ll", lock_lost, 0);
    repeat (27) @(negedge clk);
    check("pre_fail", state, SWait);
    @(negedge clk);
    check("fail_state", state, SFail);
    check("fail_err", error, 1);
    repeat (5) @(negedge clk);
    check("fail_hold", state, SFail);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_state", state, SRoc);
    check("rs_err", error, 0);

    // Stability count restarts after a low sample.
    pll_locked = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      pll_locked = pat[i];
      @(negedge clk);
      if (i == 4) check("pat_wait", state, SWait);
    end
    check("pat_rel", state, SRel);
    pll_locked = 1'b1;

    // Restart coincident with lock qualification.
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (10) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("tie_state", state, SRoc);
    repeat (7) @(negedge clk);
    check("tie_roc7", state, SRoc);
    @(negedge clk);
    check("tie_wait", state, SWait);

    // Asynchronous reset in REL_GSR.
    repeat (3) @(negedge clk);
    check("rel_state", state, SRel);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_rst", dut_vec, RstVec);
    @(negedge clk);
    resetn = 1'b1;
    repeat (7) @(negedge clk);
    check("arst_roc7", state, SRoc);
    @(negedge clk);
    check("arst_wait", state, SWait);

    // Randomized traffic: mostly-good, flaky and dead lock phases.
    mode = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      if (c % 100 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       pll_locked = ($urandom_range(0, 99) < 97);
        1:       pll_locked = ($urandom_range(0, 99) < 60);
        default: pll_locked = 1'b0;
      endcase
      restart = ($urandom_range(0, 149) == 0);
      resetn  = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    #1;
    resetn  = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/startup_seq_ctrl.md
STARTUP_SEQ_CTRL -- requirements
Module: startup_seq_ctrl

Interface
REQ-001 Parameter ROC_CYCLES, default 100, cycles global set/reset (gsr) is held after entering the ROC state (>=1).
REQ-002 Parameter TOC_CYCLES, default 4, cycles global tristate (gts) stays asserted after gsr release (>=1).
REQ-003 Parameter LOCK_STABLE, default 16, consecutive cycles pll_locked must be high before release (>=1).
REQ-004 Parameter LOCK_TIMEOUT, default 4096, maximum cycles spent in WAIT_LOCK before failure (> LOCK_STABLE).
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 pll_locked  in  1  PLL lock indication; synchronous to clk.
REQ-008 restart  in  1  single-cycle soft-restart request.
REQ-009 gsr  out  1  global set/reset, active high.
REQ-010 prld  out  1  global preload, active high; always equal to gsr.
REQ-011 gts  out  1  global tristate, active high.
REQ-012 gwe  out  1  global write enable, active high.
REQ-013 done  out  1  sequence complete (state RUN).
REQ-014 error  out  1  lock timeout (state FAIL).
REQ-015 lock_lost  out  1  sticky: lock dropped while in RUN.
REQ-016 state  out  3  encoding ROC=0, WAIT_LOCK=1, REL_GSR=2, RUN=3, FAIL=4.

Function
REQ-017 All outputs are registered and decoded from the current state. ROC: gsr=prld=gts=1, gwe=0. WAIT_LOCK: same as ROC. REL_GSR: gsr=prld=0, gts=1, gwe=0. RUN: gsr=prld=gts=0, gwe=1, done=1. FAIL: same as ROC, error=1.
REQ-018 A single cycle counter clears to 0 on every state entry and increments once per cycle while in a timed state.
REQ-019 ROC lasts exactly ROC_CYCLES cycles (exit when counter==ROC_CYCLES-1), then goes to WAIT_LOCK.
REQ-020 WAIT_LOCK: a stability counter increments while pll_locked=1 and clears to 0 on any low cycle. The FSM goes to REL_GSR on the cycle the stability counter reaches LOCK_STABLE-1 with pll_locked=1.
REQ-021 WAIT_LOCK: if the cycle counter reaches LOCK_TIMEOUT-1 without qualifying, the FSM goes to FAIL. If lock qualifies on that same cycle, lock wins and the FSM goes to REL_GSR.
REQ-022 REL_GSR lasts exactly TOC_CYCLES cycles, then goes to RUN. If pll_locked=0 in any REL_GSR cycle, the FSM goes to ROC.
REQ-023 RUN: if pll_locked=0, the FSM goes to ROC the next cycle and lock_lost is set.
REQ-024 FAIL is held until restart=1 or reset.
REQ-025 restart=1 in any state forces ROC the next cycle and clears lock_lost and error. This overrides every other transition, including one in the same cycle.
REQ-026 Counter widths are sized by $clog2 of the largest parameter plus one; counters never wrap inside a state.

Reset
REQ-027 While resetn=0: state=ROC, counters=0, gsr=prld=gts=1, gwe=done=error=lock_lost=0.
REQ-028 Reset deassertion starts the ROC count on the first clk edge with resetn=1.
REQ-029 Reset assertion mid-sequence, including in RUN, immediately and asynchronously forces the REQ-027 values.

Verification (ROC_CYCLES=8, TOC_CYCLES=4, LOCK_STABLE=3, LOCK_TIMEOUT=20)
REQ-030 Release reset with pll_locked=1 throughout: gsr=1 for 8 cycles, then 3 cycles in WAIT_LOCK, then gsr=0 with gts=1 for 4 cycles, then gwe=done=1 at cycle 15 (first post-reset edge is cycle 0).
REQ-031 pll_locked toggles 1,1,0,1,1,1 in WAIT_LOCK: the stability count restarts after the low cycle, and REL_GSR is entered after the final three highs.
REQ-032 pll_locked=0 permanently: state=FAIL and error=1 after 8+20 cycles; outputs then hold. A restart pulse gives state=ROC and error=0 the next cycle.
REQ-033 In RUN, drop pll_locked for 1 cycle: next cycle state=ROC, gsr=gts=1, gwe=0, lock_lost=1. The sequence then re-runs to RUN with lock_lost still 1.
REQ-034 restart coincident with lock qualification in WAIT_LOCK: state=ROC next cycle and the counter restarts at 0.
REQ-035 Assert resetn=0 for 1 cycle mid-REL_GSR: outputs take the REQ-027 values without waiting for a clock edge, and the full 8-cycle ROC count repeats.
